// File: rtl/gate_lab.sv
`default_nettype none
// ============================================================================
//  Module      : gate_lab
//  Description : Registered bitwise-gate demonstrator. Two WIDTH-bit operands
//                are combined by one of six bitwise ops (AND, OR, XOR, NAND,
//                NOR, XNOR). A debounced push-button steps the op through a
//                six-state ring. Result, op and a change strobe are
//                registered so they can drive LEDs directly.
//  Ports       : clk            - system clock
//                rst_n          - asynchronous active-low reset
//                a, b           - WIDTH-bit operands (asynchronous pins)
//                btn_next       - raw bouncy push-button, active-high
//                result         - registered op(a, b)
//                op             - current op code, 0..5
//                result_changed - one-cycle strobe when result changes
//  Options     : AUTO_CYCLE_EN  - when defined, a free-running counter also
//                                 steps the op every AUTO_PERIOD cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_lab #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int AUTO_PERIOD     = 12000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             btn_next,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       op,
    output logic             result_changed
);

    localparam int                C_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [C_DB_W-1:0] C_DB_LAST = C_DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] C_OP_AND  = 3'd0;
    localparam logic [2:0] C_OP_OR   = 3'd1;
    localparam logic [2:0] C_OP_XOR  = 3'd2;
    localparam logic [2:0] C_OP_NAND = 3'd3;
    localparam logic [2:0] C_OP_NOR  = 3'd4;
    localparam logic [2:0] C_OP_XNOR = 3'd5;

    // Two-flop synchronisers for every asynchronous input
    logic [WIDTH-1:0]  a_meta_q, a_sync_q;
    logic [WIDTH-1:0]  b_meta_q, b_sync_q;
    logic              btn_meta_q, btn_sync_q;

    // Debouncer
    logic [C_DB_W-1:0] db_cnt_q, db_cnt_d;
    logic              db_btn_q, db_btn_d;
    logic              db_prev_q;

    // Op FSM and registered outputs
    logic [2:0]        op_q, op_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              changed_q;

    logic              w_step;
    logic              w_advance;

    // ------------------------------------------------------------------------
    // Synchronisers and debouncer state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_meta_q   <= '0;
            a_sync_q   <= '0;
            b_meta_q   <= '0;
            b_sync_q   <= '0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            db_cnt_q   <= '0;
            db_btn_q   <= 1'b0;
            db_prev_q  <= 1'b0;
        end else begin
            a_meta_q   <= a;
            a_sync_q   <= a_meta_q;
            b_meta_q   <= b;
            b_sync_q   <= b_meta_q;
            btn_meta_q <= btn_next;
            btn_sync_q <= btn_meta_q;
            db_cnt_q   <= db_cnt_d;
            db_btn_q   <= db_btn_d;
            db_prev_q  <= db_btn_q;
        end
    end

    // The counter only runs while the synchronised level disagrees with the
    // accepted level; any agreement (a bounce back) restarts the count.
    always_comb begin
        db_cnt_d = '0;
        db_btn_d = db_btn_q;
        if (btn_sync_q != db_btn_q) begin
            if (db_cnt_q == C_DB_LAST) begin
                db_btn_d = btn_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Press edge only; the release edge never steps the op
    assign w_step = db_btn_q & ~db_prev_q;

    // ------------------------------------------------------------------------
    // Optional automatic stepping
    // ------------------------------------------------------------------------
`ifdef AUTO_CYCLE_EN
    localparam int                  C_AUTO_W    = $clog2(AUTO_PERIOD);
    localparam logic [C_AUTO_W-1:0] C_AUTO_LAST = C_AUTO_W'(AUTO_PERIOD - 1);

    logic [C_AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
    logic                w_tick;

    assign w_tick = (auto_cnt_q == C_AUTO_LAST);

    // A button step re-phases the auto period so the next automatic step is
    // a full period after the manual one.
    always_comb begin
        auto_cnt_d = auto_cnt_q + 1'b1;
        if (w_step || w_tick) begin
            auto_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end

    // OR-ing collapses a coincident step and tick into a single advance
    assign w_advance = w_step | w_tick;
`else
    logic w_unused_auto_period;
    assign w_unused_auto_period = (AUTO_PERIOD > 1);
    assign w_advance            = w_step;
`endif

    // ------------------------------------------------------------------------
    // Op FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= C_OP_AND;
            result_q  <= '0;
            changed_q <= 1'b0;
        end else begin
            op_q      <= op_d;
            result_q  <= result_d;
            changed_q <= (result_d != result_q);
        end
    end

    // ------------------------------------------------------------------------
    // Op FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        op_d = op_q;
        case (op_q)
            C_OP_AND:  if (w_advance) op_d = C_OP_OR;
            C_OP_OR:   if (w_advance) op_d = C_OP_XOR;
            C_OP_XOR:  if (w_advance) op_d = C_OP_NAND;
            C_OP_NAND: if (w_advance) op_d = C_OP_NOR;
            C_OP_NOR:  if (w_advance) op_d = C_OP_XNOR;
            C_OP_XNOR: if (w_advance) op_d = C_OP_AND;
            default:   op_d = C_OP_AND;   // recover from unreachable codes
        endcase
    end

    // ------------------------------------------------------------------------
    // Op FSM: output (gate function on synchronised operands)
    // ------------------------------------------------------------------------
    always_comb begin
        result_d = '0;
        case (op_q)
            C_OP_AND:  result_d =   a_sync_q & b_sync_q;
            C_OP_OR:   result_d =   a_sync_q | b_sync_q;
            C_OP_XOR:  result_d =   a_sync_q ^ b_sync_q;
            C_OP_NAND: result_d = ~(a_sync_q & b_sync_q);
            C_OP_NOR:  result_d = ~(a_sync_q | b_sync_q);
            C_OP_XNOR: result_d = ~(a_sync_q ^ b_sync_q);
            default:   result_d = '0;
        endcase
    end

    assign result         = result_q;
    assign op             = op_q;
    assign result_changed = changed_q;

endmodule
`default_nettype wire
